// File: rtl/prbs_checker_pkg.sv
// prbs_checker_pkg
//   Shared types and constants for the PRBS checker slice.
//   - prbs_chk_state_t : checker FSM states (SEED, ACQUIRE, LOCKED)
//   - PRBS7_*          : default PRBS7 polynomial x^7+x^6+1 (order, taps)
package prbs_checker_pkg;

    typedef enum logic [1:0] {
        SEED    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } prbs_chk_state_t;

    localparam int PRBS7_ORDER = 7;
    localparam int PRBS7_TAP_A = 7;
    localparam int PRBS7_TAP_B = 6;

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear. Clear has priority over
//   increment; the count holds at all-ones instead of wrapping.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-low reset
//     inc  - count up by one this cycle
//     clr  - synchronous clear to zero (wins over inc)
//     cnt  - current count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker
//   Self-synchronising PRBS checker for the rx sample stream. Seeds its LFSR
//   from the incoming bits, confirms LOCK_CNT consecutive predictions, then
//   free-runs its own LFSR and counts checked bits / bit errors. Too many
//   errors inside one WIN_LEN window drops lock and re-seeds.
//   Optional feature macro: PRBS_CHK_FIRST_ERR_EN (first-error index capture).
//   Ports:
//     clk           - rx sample clock
//     rst           - asynchronous active-low reset
//     in            - sampled comparator decision
//     valid         - `in` carries a new bit this cycle
//     clear_cnt     - synchronous clear of bit_cnt / err_cnt
//     locked        - checker is in LOCKED
//     err_pulse     - one-cycle pulse after a mismatched checked bit
//     bit_cnt       - bits checked while locked (saturating)
//     err_cnt       - errors while locked (saturating)
//     first_err_vld - (feature) first_err_idx holds a captured index
//     first_err_idx - (feature) bit_cnt value of the first error
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int PRBS_ORDER  = PRBS7_ORDER,
    parameter int TAP_A       = PRBS7_TAP_A,
    parameter int TAP_B       = PRBS7_TAP_B,
    parameter int LOCK_CNT    = 64,
    parameter int WIN_LEN     = 256,
    parameter int UNLOCK_ERRS = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    input  logic                 valid,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] bit_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
`ifdef PRBS_CHK_FIRST_ERR_EN
    ,
    output logic                 first_err_vld,
    output logic [CNT_WIDTH-1:0] first_err_idx
`endif
);

    localparam int SW = $clog2(PRBS_ORDER + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    localparam logic [SW-1:0] SEED_LAST  = SW'(PRBS_ORDER - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BITS_LAST  = BW'(WIN_LEN - 1);
    localparam logic [EW-1:0] ERRS_LAST  = EW'(UNLOCK_ERRS - 1);

    prbs_chk_state_t         state, state_n;
    logic [PRBS_ORDER-1:0]   sr, sr_n;
    logic [SW-1:0]           seed_cnt, seed_n;
    logic [MW-1:0]           match_cnt, match_n;
    logic [BW-1:0]           win_bits, wbits_n;
    logic [EW-1:0]           win_errs, werrs_n;
    logic                    pulse_n;
    logic                    pred, mism;
    logic                    bit_inc, err_inc;

    assign pred = sr[TAP_A-1] ^ sr[TAP_B-1];
    assign mism = (in != pred);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEED;
            sr        <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            seed_cnt  <= seed_n;
            match_cnt <= match_n;
            win_bits  <= wbits_n;
            win_errs  <= werrs_n;
            err_pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        seed_n  = seed_cnt;
        match_n = match_cnt;
        wbits_n = win_bits;
        werrs_n = win_errs;
        pulse_n = 1'b0;
        bit_inc = 1'b0;
        err_inc = 1'b0;
        if (valid) begin
            case (state)
                SEED: begin
                    sr_n = {sr[PRBS_ORDER-2:0], in};
                    if (seed_cnt == SEED_LAST) begin
                        state_n = ACQUIRE;
                        seed_n  = '0;
                        match_n = '0;
                    end else begin
                        seed_n = seed_cnt + 1'b1;
                    end
                end
                ACQUIRE: begin
                    // Shift the received bit so a wrong seed gets flushed out.
                    sr_n = {sr[PRBS_ORDER-2:0], in};
                    if (mism) begin
                        match_n = '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state_n = LOCKED;
                        match_n = '0;
                        wbits_n = '0;
                        werrs_n = '0;
                    end else begin
                        match_n = match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction: a line error is counted once
                    // instead of also corrupting the next two predictions.
                    sr_n    = {sr[PRBS_ORDER-2:0], pred};
                    bit_inc = 1'b1;
                    err_inc = mism;
                    pulse_n = mism;
                    if (mism && (win_errs == ERRS_LAST)) begin
                        // Leave in the same edge that raises err_pulse, so
                        // locked falls alongside the last error report.
                        state_n = SEED;
                        seed_n  = '0;
                        wbits_n = '0;
                        werrs_n = '0;
                    end else if (win_bits == BITS_LAST) begin
                        wbits_n = '0;
                        werrs_n = '0;
                    end else begin
                        wbits_n = win_bits + 1'b1;
                        if (mism)
                            werrs_n = win_errs + 1'b1;
                    end
                end
                default: state_n = SEED;
            endcase
        end
    end

    assign locked = (state == LOCKED);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bit_inc),
        .clr (clear_cnt),
        .cnt (bit_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clear_cnt),
        .cnt (err_cnt)
    );

`ifdef PRBS_CHK_FIRST_ERR_EN
    // Captures the pre-increment bit_cnt, i.e. the index of the failing bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (clear_cnt) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (err_inc && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= bit_cnt;
        end
    end
`endif

endmodule
